seq_mult_param: RTL

- Parametrised sequential multiplier: WIDTH×WIDTH unsigned product built from DIGIT×DIGIT partial products, one per clock.
- Generalises the fixed 8-bit, 0/4/8-bit partial-product shifter to any digit count.
- Internally sequences digit pairs, aligns each partial product by a digit-multiple shift, accumulates, and signals completion with a one-cycle done pulse.
- Sits at the top of the multiplier datapath, replacing the separate shifter/adder/counter/control arrangement.

---
 rtl/seq_mult_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_mult_param.sv
// Sequential WIDTH x WIDTH unsigned multiplier that forms one DIGIT x DIGIT partial
// product per clock, aligns it by its digit position and accumulates into a 2*WIDTH result.
module seq_mult_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_a,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int POS_W = IDX_W + 1;
  localparam int PW    = 2 * WIDTH;
  localparam int PDW   = 2 * DIGIT;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [PW-1:0]      acc_q, acc_d, prod_q, prod_d;
  logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [DIGIT-1:0]   a_dig, b_dig;
  logic [PDW-1:0]     pp;
  logic [POS_W-1:0]   pos;
  logic [PW-1:0]      pp_sh, acc_sum;

  // Constant-index mux keeps the digit select free of out-of-range part-selects.
  function automatic logic [DIGIT-1:0] digit_at(input logic [WIDTH-1:0] v,
                                                input logic [IDX_W-1:0] idx);
    logic [DIGIT-1:0] d;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) d = v[k*DIGIT +: DIGIT];
    end
    return d;
  endfunction

  function automatic logic [PW-1:0] align(input logic [PDW-1:0] p,
                                          input logic [POS_W-1:0] where);
    logic [PW-1:0] r;
    r = '0;
    for (int s = 0; s <= 2*(N-1); s++) begin
      if (where == POS_W'(s)) r = PW'(p) << (s * DIGIT);
    end
    return r;
  endfunction

  always_comb begin
    a_dig   = digit_at(a_q, i_q);
    b_dig   = digit_at(b_q, j_q);
    pp      = PDW'(a_dig) * PDW'(b_dig);
    pos     = {1'b0, i_q} + {1'b0, j_q};
    pp_sh   = align(pp, pos);
    acc_sum = acc_q + pp_sh;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    i_d     = i_q;
    j_d     = j_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dataa;
          b_d     = datab;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        if (i_q == LAST && j_q == LAST) begin
          prod_d  = acc_sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          i_d     = '0;
          j_d     = '0;
          state_d = IDLE;
        end else if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + IDX_W'(1);
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      i_q     <= i_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign product = prod_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
